// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_STATES access delay,
// response held until taken. Optional per-word even parity under `MEMRESP_PARITY_EN`.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_sys_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [15:0] resp_rdata_o,
`ifdef MEMRESP_PARITY_EN
  input  logic        inj_perr_i,
  output logic        parity_err_o,
`endif
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
`ifdef MEMRESP_PARITY_EN
  localparam int MW = 17;
`else
  localparam int MW = 16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [MW-1:0]          mem_q [DEPTH];
  logic                   mem_we;
  logic [MW-1:0]          mem_wword;
  logic [MW-1:0]          rd_word;
`ifdef MEMRESP_PARITY_EN
  logic                   inj_q, inj_d;
  logic                   perr_q, perr_d;
`endif

  // Address bits above ADDR_BITS are deliberately dropped (addresses wrap).
  generate
    if (ADDR_BITS < 16) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr_i[15:ADDR_BITS];
    end
  endgenerate

  assign req_ready_o  = (state_q == S_IDLE) && !halt_sys_i && rst_i;
  assign resp_valid_o = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_rdata_o = rdata_q;
`ifdef MEMRESP_PARITY_EN
  assign parity_err_o = perr_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_wword = '0;
    rd_word   = mem_q[addr_q];
`ifdef MEMRESP_PARITY_EN
    inj_d     = inj_q;
    perr_d    = perr_q;
`endif
    // Halt freezes every register, so all transitions sit under !halt.
    if (!halt_sys_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            wr_d    = req_write_i;
            addr_d  = req_addr_i[ADDR_BITS-1:0];
            wdata_d = req_wdata_i;
`ifdef MEMRESP_PARITY_EN
            inj_d   = inj_perr_i;
`endif
            cnt_d   = WAIT_STATES[3:0];
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = S_RESP;
            if (wr_q) begin
              mem_we  = 1'b1;
              rdata_d = wdata_q;
`ifdef MEMRESP_PARITY_EN
              mem_wword = {(^wdata_q) ^ inj_q, wdata_q};
              perr_d    = 1'b0;
`else
              mem_wword = wdata_q;
`endif
            end else begin
              rdata_d = rd_word[15:0];
`ifdef MEMRESP_PARITY_EN
              // Even parity over all 17 bits: any odd count is a mismatch.
              perr_d  = ^rd_word;
`endif
            end
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_d = S_IDLE;
`ifdef MEMRESP_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEMRESP_PARITY_EN
      inj_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEMRESP_PARITY_EN
      inj_q   <= inj_d;
      perr_q  <= perr_d;
`endif
      if (mem_we) mem_q[addr_q] <= mem_wword;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder: the memory-side end of the load/store interface driven by the pipeline's memory stage. Accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, performs the word read or write on an internal 16-bit array, then presents a response until the requester takes it. Stalls entirely under `halt_sys`, like the rest of the datapath.

## Interface
Parameters:
- ADDR_BITS, 8: word-address width; array depth is 2^ADDR_BITS 16-bit words.
- WAIT_STATES, 2: extra access cycles; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- halt_sys  in  1  system halt; freezes all state.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  word address; only bits [ADDR_BITS-1:0] are used.
- req_wdata  in  16  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  16  load data; write data echoed for stores.
- busy  out  1  a request is in flight (state != IDLE).
- inj_perr  in  1  (MEMRESP_PARITY_EN only) flip the stored parity bit on this write.
- parity_err  out  1  (MEMRESP_PARITY_EN only) parity mismatch on the current read response.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) && !halt_sys && rst. It is combinational.
- IDLE: accept when req_valid && req_ready. The request is latched into regs (write, addr[ADDR_BITS-1:0], wdata). The counter loads WAIT_STATES and the FSM moves to WAIT.
- WAIT with counter != 0: decrement the counter.
- WAIT with counter == 0:
  - Perform the access. A store writes the array and sets resp_rdata = wdata. A load sets resp_rdata = array[addr].
  - Move to RESP.
- RESP:
  - resp_valid = 1 and resp_rdata is held stable.
  - When resp_ready && !halt_sys, return to IDLE and drop resp_valid.
- Only one request is outstanding at a time; req_ready stays low from accept until the cycle after the response handshake.
- Upper address bits above ADDR_BITS are ignored, so addresses wrap modulo 2^ADDR_BITS.
- halt_sys high:
  - no state, counter, array or output register changes;
  - req_ready is forced 0;
  - a response handshake does not complete;
  - resp_valid and resp_rdata hold their values.

## Timing
- Reset (rst low at a clk edge):
  - state = IDLE, counter = 0;
  - resp_valid = 0, resp_rdata = 0, busy = 0, parity_err = 0;
  - all array words = 0 (array cleared synchronously);
  - req_ready = 0 while rst is low.
- Latency: a request accepted at edge N gives resp_valid high after edge N+WAIT_STATES+1, when halt_sys stays low.
- Minimum request-to-request period: WAIT_STATES+3 cycles (accept, waits, access, response handshake, return to IDLE).
- A store commits to the array at the access edge, not at accept.
- Reset during WAIT: the request is abandoned and an uncommitted store is not written.
- Reset during RESP: resp_valid drops and the response is lost.
- Halt during WAIT extends latency by the number of halted cycles.
- Simultaneous resp_ready and a new req_valid in RESP: only the response completes. The new request is accepted at the earliest next cycle.

## Configuration
- MEMRESP_PARITY_EN defined:
  - each array word stores 17 bits: data plus even parity;
  - parity is computed at the store commit and inverted when inj_perr was 1 at accept;
  - a load response asserts parity_err with resp_valid when the recomputed parity mismatches;
  - parity_err clears with resp_valid;
  - store responses always give parity_err = 0.
- MEMRESP_PARITY_EN undefined: 16-bit array, and neither inj_perr nor parity_err exists.

## Test plan
- Reset, then load addr 0x0005 with WAIT_STATES=2 → resp_valid high 3 cycles after accept, resp_rdata = 0x0000; req_ready low until the cycle after the handshake.
- Store 0xBEEF to 0x0012, then load 0x0012 → store echo 0xBEEF, then load returns 0xBEEF. With ADDR_BITS=8, a load from 0x0112 also returns 0xBEEF (wrap).
- Hold resp_ready low for 4 cycles in RESP → resp_valid and resp_rdata stable; no new request accepted despite req_valid=1.
- Assert halt_sys for 3 cycles during WAIT → resp_valid delayed by exactly 3 cycles; array unchanged during the halt; req_ready = 0 throughout.
- Store 0x1234 to 0x0020, then pulse rst low during the WAIT of a store of 0x5555 to 0x0020 → all outputs at reset values. After reset, a load of 0x0020 returns 0x0000 (array cleared, aborted store not committed).
- With MEMRESP_PARITY_EN: store 0x00FF with inj_perr=1, then load → parity_err=1 with resp_valid. A store and load of 0x00FF with inj_perr=0 → parity_err=0.
